control_pipeline: RTL and testbench

Pipelined consumer of the decoder's control bundle. Registers the per-instruction control signals and register addresses through the EX, MEM and WB stages, and drops them stage by stage as each is consumed. Detects load-use hazards and produces the stall and bubble. Generates EX-stage operand-forwarding selects. Sits between the opcode decoder and the datapath's ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/control_pipeline.sv | 162 ++++++++++++++++
 tb/tb_control_pipeline.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipeline.sv
// Carries decoder control bits through the EX, MEM and WB stages (1/2/3 cycles after ID).
// Flags load-use stalls and selects EX operand forwarding; a flush bubbles EX and MEM.
module control_pipeline (
    input  logic       clk,
    input  logic       reset,
    input  logic       reg_dst_i,
    input  logic       alu_src_i,
    input  logic       mem_to_reg_i,
    input  logic       reg_write_i,
    input  logic       mem_read_i,
    input  logic       mem_write_i,
    input  logic       branch_ne_i,
    input  logic       branch_eq_i,
    input  logic [2:0] alu_op_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic [4:0] id_rd_i,
    input  logic       flush_i,
    output logic       ex_reg_dst_o,
    output logic       ex_alu_src_o,
    output logic [2:0] ex_alu_op_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       mem_branch_ne_o,
    output logic       mem_branch_eq_o,
    output logic       wb_mem_to_reg_o,
    output logic       wb_reg_write_o,
    output logic [4:0] wb_write_reg_o,
    output logic       stall_o,
    output logic [1:0] forward_a_o,
    output logic [1:0] forward_b_o
);

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch_ne;
        logic       branch_eq;
        logic [2:0] alu_op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ex_t;

    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch_ne;
        logic       branch_eq;
        logic [4:0] write_reg;
    } mem_t;

    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic [4:0] write_reg;
    } wb_t;

    ex_t  ex_q,  ex_d;
    mem_t mem_q, mem_d;
    wb_t  wb_q,  wb_d;

    logic [4:0] ex_write_reg;
    logic       stall;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       m_we,
        input logic [4:0] m_reg,
        input logic       w_we,
        input logic [4:0] w_reg
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_we && (m_reg != 5'd0) && (m_reg == src)) begin
            sel = 2'b10;
        end else if (w_we && (w_reg != 5'd0) && (w_reg == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign ex_write_reg = ex_q.reg_dst ? ex_q.rd : ex_q.rt;

    // A load whose result is needed by the very next instruction cannot be forwarded in time.
    assign stall = ex_q.mem_read && (ex_q.rt != 5'd0)
                   && ((ex_q.rt == id_rs_i) || (ex_q.rt == id_rt_i))
                   && !flush_i;

    always_comb begin
        ex_d = '0;
        if (!(flush_i || stall)) begin
            ex_d.reg_dst    = reg_dst_i;
            ex_d.alu_src    = alu_src_i;
            ex_d.mem_to_reg = mem_to_reg_i;
            ex_d.reg_write  = reg_write_i;
            ex_d.mem_read   = mem_read_i;
            ex_d.mem_write  = mem_write_i;
            ex_d.branch_ne  = branch_ne_i;
            ex_d.branch_eq  = branch_eq_i;
            ex_d.alu_op     = alu_op_i;
            ex_d.rs         = id_rs_i;
            ex_d.rt         = id_rt_i;
            ex_d.rd         = id_rd_i;
        end
    end

    always_comb begin
        mem_d = '0;
        if (!flush_i) begin
            mem_d.mem_to_reg = ex_q.mem_to_reg;
            mem_d.reg_write  = ex_q.reg_write;
            mem_d.mem_read   = ex_q.mem_read;
            mem_d.mem_write  = ex_q.mem_write;
            mem_d.branch_ne  = ex_q.branch_ne;
            mem_d.branch_eq  = ex_q.branch_eq;
            mem_d.write_reg  = ex_write_reg;
        end
    end

    always_comb begin
        wb_d            = '0;
        wb_d.mem_to_reg = mem_q.mem_to_reg;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.write_reg  = mem_q.write_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_reg_dst_o    = ex_q.reg_dst;
    assign ex_alu_src_o    = ex_q.alu_src;
    assign ex_alu_op_o     = ex_q.alu_op;
    assign mem_read_o      = mem_q.mem_read;
    assign mem_write_o     = mem_q.mem_write;
    assign mem_branch_ne_o = mem_q.branch_ne;
    assign mem_branch_eq_o = mem_q.branch_eq;
    assign wb_mem_to_reg_o = wb_q.mem_to_reg;
    assign wb_reg_write_o  = wb_q.reg_write;
    assign wb_write_reg_o  = wb_q.write_reg;
    assign stall_o         = stall;
    assign forward_a_o     = fwd_sel(ex_q.rs, mem_q.reg_write, mem_q.write_reg,
                                     wb_q.reg_write, wb_q.write_reg);
    assign forward_b_o     = fwd_sel(ex_q.rt, mem_q.reg_write, mem_q.write_reg,
                                     wb_q.reg_write, wb_q.write_reg);

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench: each drive step queues the outputs it should cause, tagged with the cycle they are due.
module tb_control_pipeline;

    logic       clk;
    logic       reset;
    logic       reg_dst_i, alu_src_i, mem_to_reg_i, reg_write_i;
    logic       mem_read_i, mem_write_i, branch_ne_i, branch_eq_i;
    logic [2:0] alu_op_i;
    logic [4:0] id_rs_i, id_rt_i, id_rd_i;
    logic       flush_i;
    logic       ex_reg_dst_o, ex_alu_src_o;
    logic [2:0] ex_alu_op_o;
    logic       mem_read_o, mem_write_o, mem_branch_ne_o, mem_branch_eq_o;
    logic       wb_mem_to_reg_o, wb_reg_write_o;
    logic [4:0] wb_write_reg_o;
    logic       stall_o;
    logic [1:0] forward_a_o, forward_b_o;

    control_pipeline dut (
        .clk            (clk),
        .reset          (reset),
        .reg_dst_i      (reg_dst_i),
        .alu_src_i      (alu_src_i),
        .mem_to_reg_i   (mem_to_reg_i),
        .reg_write_i    (reg_write_i),
        .mem_read_i     (mem_read_i),
        .mem_write_i    (mem_write_i),
        .branch_ne_i    (branch_ne_i),
        .branch_eq_i    (branch_eq_i),
        .alu_op_i       (alu_op_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_rd_i        (id_rd_i),
        .flush_i        (flush_i),
        .ex_reg_dst_o   (ex_reg_dst_o),
        .ex_alu_src_o   (ex_alu_src_o),
        .ex_alu_op_o    (ex_alu_op_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .mem_branch_ne_o(mem_branch_ne_o),
        .mem_branch_eq_o(mem_branch_eq_o),
        .wb_mem_to_reg_o(wb_mem_to_reg_o),
        .wb_reg_write_o (wb_reg_write_o),
        .wb_write_reg_o (wb_write_reg_o),
        .stall_o        (stall_o),
        .forward_a_o    (forward_a_o),
        .forward_b_o    (forward_b_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_EX_RDST = 0,  S_EX_ASRC = 1,  S_EX_AOP = 2,   S_MEM_RD = 3;
    localparam int S_MEM_WR  = 4,  S_MEM_BNE = 5,  S_MEM_BEQ = 6,  S_WB_M2R = 7;
    localparam int S_WB_RW   = 8,  S_WB_WR   = 9,  S_STALL   = 10, S_FWD_A  = 11;
    localparam int S_FWD_B   = 12;

    typedef struct {
        int         due;
        int         sig;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   vectors;
    int   miscompares;

    function automatic logic [7:0] observe(input int s);
        logic [7:0] v;
        v = 8'h00;
        case (s)
            S_EX_RDST: v = {7'd0, ex_reg_dst_o};
            S_EX_ASRC: v = {7'd0, ex_alu_src_o};
            S_EX_AOP:  v = {5'd0, ex_alu_op_o};
            S_MEM_RD:  v = {7'd0, mem_read_o};
            S_MEM_WR:  v = {7'd0, mem_write_o};
            S_MEM_BNE: v = {7'd0, mem_branch_ne_o};
            S_MEM_BEQ: v = {7'd0, mem_branch_eq_o};
            S_WB_M2R:  v = {7'd0, wb_mem_to_reg_o};
            S_WB_RW:   v = {7'd0, wb_reg_write_o};
            S_WB_WR:   v = {3'd0, wb_write_reg_o};
            S_STALL:   v = {7'd0, stall_o};
            S_FWD_A:   v = {6'd0, forward_a_o};
            S_FWD_B:   v = {6'd0, forward_b_o};
            default:   v = 8'hff;
        endcase
        return v;
    endfunction

    task automatic expect_at(input string tag, input int sig, input logic [7:0] val, input int off);
        exp_t e;
        e.due = cyc + off;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic expect_all_zero(input string tag, input int off);
        for (int s = S_EX_RDST; s <= S_FWD_B; s++) expect_at(tag, s, 8'h00, off);
    endtask

    task automatic check_due();
        int         i;
        logic [7:0] obs;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].due == cyc) begin
                obs = observe(exp_q[i].sig);
                vectors++;
                assert (obs === exp_q[i].val) else begin
                    miscompares++;
                    $error("FAIL %s (sig %0d, cycle %0d): observed %0h expected %0h",
                           exp_q[i].tag, exp_q[i].sig, cyc, obs, exp_q[i].val);
                end
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    // Inputs are applied just after a rising edge, checked mid-cycle, then the clock advances.
    task automatic step();
        #1;
        check_due();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic rdst, input logic asrc, input logic m2r, input logic rw,
                         input logic mr, input logic mw, input logic bne, input logic beq,
                         input logic [2:0] aop, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic fl);
        reg_dst_i    = rdst;
        alu_src_i    = asrc;
        mem_to_reg_i = m2r;
        reg_write_i  = rw;
        mem_read_i   = mr;
        mem_write_i  = mw;
        branch_ne_i  = bne;
        branch_eq_i  = beq;
        alu_op_i     = aop;
        id_rs_i      = rs;
        id_rt_i      = rt;
        id_rd_i      = rd;
        flush_i      = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        reset       = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        expect_all_zero("reset_state", 0);
        step();

        // R-type with rd=5, a second one behind it, then reset mid-flight
        drive(1, 0, 0, 1, 0, 0, 0, 0, 3'd7, 5'd1, 5'd2, 5'd5, 0);
        expect_at("rtype_ex_aop", S_EX_AOP, 8'd7, 1);
        expect_at("rtype_ex_rdst", S_EX_RDST, 8'd1, 1);
        expect_at("rtype_wb_rw", S_WB_RW, 8'd1, 3);
        expect_at("rtype_wb_wr", S_WB_WR, 8'd5, 3);
        step();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 3'd7, 5'd1, 5'd2, 5'd9, 0);
        step();
        idle();
        step();
        reset = 1'b1;
        drive(1, 1, 0, 1, 0, 0, 0, 0, 3'd7, 5'd3, 5'd4, 5'd11, 0);
        expect_all_zero("midrun_reset", 1);
        step();
        reset = 1'b0;

        // lw $8 followed by a reader of $8
        drive(0, 1, 1, 1, 1, 0, 0, 0, 3'd0, 5'd1, 5'd8, 5'd0, 0);
        expect_at("lw_mem_read", S_MEM_RD, 8'd1, 2);
        step();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 3'd2, 5'd8, 5'd9, 5'd10, 0);
        expect_at("loaduse_stall", S_STALL, 8'd1, 0);
        expect_at("bubble_ex_rdst", S_EX_RDST, 8'd0, 1);
        expect_at("bubble_ex_asrc", S_EX_ASRC, 8'd0, 1);
        expect_at("bubble_ex_aop", S_EX_AOP, 8'd0, 1);
        step();
        expect_at("stall_one_cycle", S_STALL, 8'd0, 0);
        expect_at("bubble_fwd_a", S_FWD_A, 8'd0, 0);
        expect_at("lu_fwd_a_wb", S_FWD_A, 8'd1, 1);
        expect_at("lu_fwd_b_none", S_FWD_B, 8'd0, 1);
        expect_at("lu_wb_wr", S_WB_WR, 8'd8, 1);
        expect_at("lu_add_in_ex", S_EX_AOP, 8'd2, 1);
        step();
        idle();
        step();

        // add $3 then sub $4,$3,$3 back to back
        drive(1, 0, 0, 1, 0, 0, 0, 0, 3'd2, 5'd1, 5'd2, 5'd3, 0);
        step();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 3'd6, 5'd3, 5'd3, 5'd4, 0);
        expect_at("b2b_fwd_a_mem", S_FWD_A, 8'd2, 1);
        expect_at("b2b_fwd_b_mem", S_FWD_B, 8'd2, 1);
        step();
        // same pair with an independent instruction between them
        drive(1, 0, 0, 1, 0, 0, 0, 0, 3'd2, 5'd1, 5'd2, 5'd3, 0);
        step();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 3'd2, 5'd1, 5'd2, 5'd7, 0);
        step();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 3'd6, 5'd3, 5'd3, 5'd4, 0);
        expect_at("gap_fwd_a_wb", S_FWD_A, 8'd1, 1);
        expect_at("gap_fwd_b_wb", S_FWD_B, 8'd1, 1);
        step();
        idle();
        step();

        // two writes to $6 then a reader: MEM beats WB
        drive(1, 0, 0, 1, 0, 0, 0, 0, 3'd2, 5'd1, 5'd2, 5'd6, 0);
        step();
        drive(1, 0, 0, 1, 0, 0, 0, 0, 3'd2, 5'd2, 5'd1, 5'd6, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 3'd1, 5'd6, 5'd0, 5'd15, 0);
        expect_at("prio_fwd_a_mem", S_FWD_A, 8'd2, 1);
        expect_at("prio_fwd_b_none", S_FWD_B, 8'd0, 1);
        step();

        // load into $0 then a reader of $0: neither stall nor forward
        drive(0, 1, 1, 1, 1, 0, 0, 0, 3'd0, 5'd1, 5'd0, 5'd0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3'd3, 5'd0, 5'd0, 5'd0, 0);
        expect_at("r0_no_stall", S_STALL, 8'd0, 0);
        expect_at("r0_fwd_a", S_FWD_A, 8'd0, 1);
        expect_at("r0_fwd_b", S_FWD_B, 8'd0, 1);
        step();

        // distinctive instruction that will sit in MEM when the flush hits
        drive(1, 1, 1, 1, 0, 1, 1, 1, 3'd5, 5'd1, 5'd2, 5'd20, 0);
        expect_at("mark_ex_asrc", S_EX_ASRC, 8'd1, 1);
        expect_at("mark_ex_aop", S_EX_AOP, 8'd5, 1);
        expect_at("mark_mem_wr", S_MEM_WR, 8'd1, 2);
        expect_at("mark_mem_bne", S_MEM_BNE, 8'd1, 2);
        expect_at("mark_mem_beq", S_MEM_BEQ, 8'd1, 2);
        expect_at("flush_wb_m2r", S_WB_M2R, 8'd1, 3);
        expect_at("flush_wb_rw", S_WB_RW, 8'd1, 3);
        expect_at("flush_wb_wr", S_WB_WR, 8'd20, 3);
        step();
        drive(0, 1, 1, 1, 1, 0, 0, 0, 3'd0, 5'd1, 5'd12, 5'd0, 0);
        step();
        // flush arrives together with a load-use match on $12
        drive(1, 0, 0, 1, 0, 0, 0, 0, 3'd2, 5'd12, 5'd1, 5'd13, 1);
        expect_at("flush_no_stall", S_STALL, 8'd0, 0);
        expect_at("flush_ex_rdst", S_EX_RDST, 8'd0, 1);
        expect_at("flush_ex_asrc", S_EX_ASRC, 8'd0, 1);
        expect_at("flush_ex_aop", S_EX_AOP, 8'd0, 1);
        expect_at("flush_mem_rd", S_MEM_RD, 8'd0, 1);
        expect_at("flush_mem_wr", S_MEM_WR, 8'd0, 1);
        expect_at("flush_mem_bne", S_MEM_BNE, 8'd0, 1);
        expect_at("flush_mem_beq", S_MEM_BEQ, 8'd0, 1);
        step();
        idle();
        expect_at("flushed_lw_gone", S_WB_RW, 8'd0, 1);
        step();
        step();
        step();

        while (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $error("FAIL undrained %s: due cycle %0d never reached", exp_q[0].tag, exp_q[0].due);
            exp_q.delete(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
